// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
// Owns the fetch PC and issues word reads to a 1-cycle-latency instruction memory.
// Returned words are buffered with their byte PC in a small FIFO and handed to decode
// over a valid/ready handshake. A redirect reloads the PC and flushes everything in flight.
//
// Ports:
//   Clk          rising-edge clock
//   Reset        synchronous active-low reset (0 = reset)
//   redirect     load redirect_pc and flush queue and pending response
//   redirect_pc  new byte PC, bits [1:0] ignored
//   imem_req     read request to instruction memory this cycle
//   imem_addr    word address of the request (fetch_pc[ADDR_W+1:2])
//   imem_rdata   instruction word, valid the cycle after imem_req
//   inst_valid   head of queue holds a valid instruction
//   inst         head instruction word (0 when inst_valid=0)
//   inst_pc      byte PC of head instruction (0 when inst_valid=0)
//   inst_ready   decode accepts the head this cycle
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ADDR_W   = 10,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic              inst_valid,
   output logic [31:0]       inst,
   output logic [31:0]       inst_pc,
   input  logic              inst_ready
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     pend_pc_q, pend_pc_d;
   logic            pend_q, pend_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   logic [31:0]     fifo_inst_q [DEPTH];
   logic [31:0]     fifo_pc_q   [DEPTH];

   logic            issue;
   logic            push;
   logic            pop;

   always_comb begin
      // A pending response already owns a slot, so issue only when count + pend leaves room.
      issue = Reset & ~redirect & ((32'(count_q) + 32'(pend_q)) < DEPTH);
      // A response arriving during a redirect belongs to the old path and is dropped.
      push  = Reset & pend_q & ~redirect;
      pop   = inst_valid & inst_ready;
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      pend_pc_d  = pend_pc_q;
      pend_d     = issue;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;

      if (issue) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         pend_pc_d  = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      // Redirect wins over everything above; a same-cycle pop has already been seen by decode.
      if (redirect) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         pend_d     = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         fetch_pc_q <= {RESET_PC[31:2], 2'b00};
         pend_pc_q  <= '0;
         pend_q     <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         pend_pc_q  <= pend_pc_d;
         pend_q     <= pend_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: outputs are gated by count.
   always_ff @(posedge Clk) begin
      if (push) begin
         fifo_inst_q[wr_ptr_q] <= imem_rdata;
         fifo_pc_q[wr_ptr_q]   <= pend_pc_q;
      end
   end

   always_comb begin
      imem_req   = issue;
      imem_addr  = fetch_pc_q[ADDR_W+1:2];
      inst_valid = (count_q != '0);
      inst       = inst_valid ? fifo_inst_q[rd_ptr_q] : 32'd0;
      inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : 32'd0;
   end

endmodule
